// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings,
// bounce direction type and the counter-width helper.
package led_pattern_sequencer_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Number of bits needed to hold the value itself (not value-1), so a
  // counter sized clogb2(W) can reach W as the fill pattern requires.
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_frame_decode.sv
// Combinational frame decode: turns registered pattern state into LED drive.
module led_pattern_sequencer_frame_decode
  import led_pattern_sequencer_pkg::*;
#(
  parameter int W     = 10,
  parameter int CNT_W = clogb2(W)
) (
  input  logic [1:0]       mode_q,
  input  logic [CNT_W-1:0] pos,
  input  logic [CNT_W-1:0] fill,
  input  logic             phase,
  output logic [W-1:0]     leds
);

  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ONES_W = {W{1'b1}};

  // Select the frame for the active pattern; a shift of W or more yields
  // zero, so the inverted fill mask covers the all-on frame at fill==W.
  always_comb begin
    leds = '0;
    case (mode_q)
      MODE_BOUNCE: leds = ONE_W << pos;
      MODE_FILL:   leds = ~(ONES_W << fill);
      MODE_BLINK:  leds = {W{phase}};
      default:     leds = '0;
    endcase
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED animation stage: advances the selected pattern one step per tick,
// restarts cleanly on a mode change and flags each completed period.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         tick,
  input  logic [1:0]   mode,
  input  logic         run,
  output logic [W-1:0] leds,
  output logic         cycle_done
);

  localparam int CNT_W = clogb2(W);
  localparam logic [CNT_W-1:0] POS_MAX  = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  dir_e             dir_q, dir_d;
  logic             phase_q, phase_d;
  logic             cycle_done_q, cycle_done_d;

  // Next-state: a mode change restarts the pattern and swallows any tick;
  // otherwise a tick with run high advances the active pattern.
  always_comb begin
    mode_d       = mode_q;
    pos_d        = pos_q;
    fill_d       = fill_q;
    dir_d        = dir_q;
    phase_d      = phase_q;
    cycle_done_d = 1'b0;
    if (mode != mode_q) begin
      mode_d  = mode;
      pos_d   = '0;
      fill_d  = '0;
      dir_d   = DIR_UP;
      phase_d = 1'b0;
    end else if (tick && run) begin
      case (mode_q)
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_MAX) begin
              pos_d = POS_MAX - CNT_ONE;
              // With only two LEDs the turnaround lands straight back on 0.
              if (POS_MAX == CNT_ONE) begin
                dir_d        = DIR_UP;
                cycle_done_d = 1'b1;
              end else begin
                dir_d = DIR_DOWN;
              end
            end else begin
              pos_d = pos_q + CNT_ONE;
            end
          end else begin
            if (pos_q <= CNT_ONE) begin
              pos_d        = '0;
              dir_d        = DIR_UP;
              cycle_done_d = 1'b1;
            end else begin
              pos_d = pos_q - CNT_ONE;
            end
          end
        end
        MODE_FILL: begin
          if (fill_q == FILL_MAX) begin
            fill_d       = '0;
            cycle_done_d = 1'b1;
          end else begin
            fill_d = fill_q + CNT_ONE;
          end
        end
        MODE_BLINK: begin
          phase_d      = ~phase_q;
          cycle_done_d = phase_q;
        end
        default: ;
      endcase
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      mode_q       <= MODE_OFF;
      pos_q        <= '0;
      fill_q       <= '0;
      dir_q        <= DIR_UP;
      phase_q      <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      fill_q       <= fill_d;
      dir_q        <= dir_d;
      phase_q      <= phase_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign cycle_done = cycle_done_q;

  led_pattern_sequencer_frame_decode #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_frame_decode (
    .mode_q (mode_q),
    .pos    (pos_q),
    .fill   (fill_q),
    .phase  (phase_q),
    .leds   (leds)
  );

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for the LED pattern sequencer at W=4 with a scoreboard
// of expected frames and period-complete flags.
module tb_led_pattern_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         aclr;
  logic         tick;
  logic [1:0]   mode;
  logic         run;
  logic [W-1:0] leds;
  logic         cycle_done;

  typedef struct {
    logic [W-1:0] leds;
    logic         done;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  led_pattern_sequencer #(.W(W)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .tick       (tick),
    .mode       (mode),
    .run        (run),
    .leds       (leds),
    .cycle_done (cycle_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_leds(input string tag, input logic [W-1:0] exp_l);
    vectors++;
    assert (leds === exp_l) else begin
      miscompares++;
      $error("FAIL %s: leds observed %b expected %b", tag, leds, exp_l);
    end
  endtask

  task automatic check_done(input string tag, input logic exp_d);
    vectors++;
    assert (cycle_done === exp_d) else begin
      miscompares++;
      $error("FAIL %s: cycle_done observed %b expected %b", tag, cycle_done, exp_d);
    end
  endtask

  // Called at a negedge: drive tick for one clk, score the frame after the edge.
  task automatic step(input string tag, input logic t,
                      input logic [W-1:0] exp_l, input logic exp_d);
    exp_t e;
    exp_t got;
    e.leds = exp_l;
    e.done = exp_d;
    e.tag  = tag;
    exp_q.push_back(e);
    tick = t;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed leds %b", tag, leds);
    end else begin
      got = exp_q.pop_front();
      check_leds(got.tag, got.leds);
      check_done(got.tag, got.done);
    end
  endtask

  // Idle clocks: frame must hold and no period flag may appear.
  task automatic idle(input string tag, input int n, input logic [W-1:0] exp_l);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_leds(tag, exp_l);
      check_done(tag, 1'b0);
    end
  endtask

  logic [W-1:0] bounce_seq [7];
  logic         bounce_done [7];
  logic [W-1:0] fill_seq [6];
  logic         fill_done [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    aclr = 1'b0;
    tick = 1'b0;
    mode = 2'b01;
    run  = 1'b1;
    bounce_seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    bounce_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fill_seq    = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};
    fill_done   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    #12;
    check_leds("reset_leds", 4'b0000);
    check_done("reset_done", 1'b0);
    @(negedge clk);
    aclr = 1'b1;

    // Mode 01 held through reset release: first edge enters bounce at pos 0.
    step("bounce_entry", 1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step($sformatf("bounce_%0d", i), 1'b1, bounce_seq[i], bounce_done[i]);
      idle($sformatf("bounce_idle_%0d", i), 4, bounce_seq[i]);
    end

    // Mid-bounce asynchronous reset at pos=2.
    step("bounce_to_pos2", 1'b1, 4'b0100, 1'b0);
    #2;
    aclr = 1'b0;
    #1;
    check_leds("async_reset_leds", 4'b0000);
    check_done("async_reset_done", 1'b0);
    @(negedge clk);
    aclr = 1'b1;
    step("post_reset_entry", 1'b0, 4'b0001, 1'b0);

    // Fill pattern.
    mode = 2'b10;
    step("fill_entry", 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step($sformatf("fill_%0d", i), 1'b1, fill_seq[i], fill_done[i]);
      idle($sformatf("fill_idle_%0d", i), 2, fill_seq[i]);
    end

    // Blink, frozen then running.
    mode = 2'b11;
    step("blink_entry", 1'b0, 4'b0000, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("blink_frozen_%0d", i), 1'b1, 4'b0000, 1'b0);
      idle("blink_frozen_idle", 2, 4'b0000);
    end
    run = 1'b1;
    step("blink_on", 1'b1, 4'b1111, 1'b0);
    idle("blink_on_idle", 3, 4'b1111);
    step("blink_off", 1'b1, 4'b0000, 1'b1);
    idle("blink_off_idle", 3, 4'b0000);

    // Mode change coincident with a tick: tick discarded.
    mode = 2'b01;
    step("bounce2_entry", 1'b0, 4'b0001, 1'b0);
    step("bounce2_1", 1'b1, 4'b0010, 1'b0);
    step("bounce2_2", 1'b1, 4'b0100, 1'b0);
    step("bounce2_3", 1'b1, 4'b1000, 1'b0);
    mode = 2'b10;
    step("mode_change_tick", 1'b1, 4'b0000, 1'b0);
    idle("mode_change_idle", 2, 4'b0000);
    step("fill_after_change", 1'b1, 4'b0001, 1'b0);

    // Off: ticks do nothing.
    mode = 2'b00;
    step("off_entry", 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("off_%0d", i), 1'b1, 4'b0000, 1'b0);
      idle("off_idle", 1, 4'b0000);
    end

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
